// File: rtl/sram_burst_reader_pkg.sv
// Shared definitions for the SRAM burst reader: default widths, FSM states
// and the read-issue credit rule.
package sram_burst_reader_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 11;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } state_e;

  // A new read may only start if, after this cycle's transfer, at most one
  // byte is already committed, so a returning read always finds a free slot.
  function automatic logic may_issue(input logic [1:0] occupancy,
                                     input logic       in_flight,
                                     input logic       xfer);
    logic [2:0] pending;
    pending = {1'b0, occupancy} + {2'b00, in_flight};
    return pending <= ({2'b00, xfer} + 3'd1);
  endfunction

endpackage

// File: rtl/byte_skid_buffer.sv
// Two-entry valid/ready buffer: a head register that drives the consumer and
// a skid register that absorbs one byte while the head is stalled.
module byte_skid_buffer
  import sram_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  head_free;

  assign in_ready  = !skid_valid;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign head_free = !out_valid || out_xfer;
  assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

  // NOTE: state registers use <= so every flop samples pre-edge values;
  // blocking here would make the result depend on statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (head_free) begin
      // The skid entry is older than anything arriving now, so it goes first.
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/sram_burst_reader.sv
// Streams a burst of bytes out of a synchronous single-port RAM, keeping at
// most two bytes buffered so the consumer can stall without losing data.
module sram_burst_reader
  import sram_burst_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  startBurst,
  input  logic [ADDR_WIDTH-1:0] startAddress,
  input  logic [ADDR_WIDTH:0]   burstLength,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic                  memWriteEnable,
  input  logic [DATA_WIDTH-1:0] memDataOut,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  input  logic                  dataReady,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e              state;
  state_e              state_next;
  logic [ADDR_WIDTH:0] remaining;
  logic                in_flight;
  logic                accept;
  logic                issue;
  logic                xfer;
  logic                buf_in_ready;
  logic [1:0]          occupancy;

  assign memWriteEnable = 1'b0;
  assign xfer           = dataValid && dataReady;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (startBurst) begin
          if (burstLength != '0) begin
            accept     = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = FINISH;
          end
        end
      end
      ISSUE: begin
        busy  = 1'b1;
        issue = may_issue(occupancy, in_flight, xfer) && buf_in_ready;
        if (issue && remaining == LEN_ONE) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // Last byte leaves when it is the only one held and nothing is returning.
        if (xfer && occupancy == 2'd1 && !in_flight) state_next = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // memAddress is the address the RAM samples at the end of the current
  // cycle; an issue advances it and marks one read as in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      memAddress <= '0;
      remaining  <= '0;
      in_flight  <= 1'b0;
    end else begin
      in_flight <= issue;
      if (accept) begin
        memAddress <= startAddress;
        remaining  <= burstLength;
      end else if (issue) begin
        memAddress <= memAddress + 1'b1;
        remaining  <= remaining - 1'b1;
      end
    end
  end

  byte_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buffer (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_flight),
    .in_ready (buf_in_ready),
    .in_data  (memDataOut),
    .out_valid(dataValid),
    .out_ready(dataReady),
    .out_data (dataOut),
    .occupancy(occupancy)
  );

endmodule

// File: tb/tb_sram_burst_reader.sv
// Self-checking bench for sram_burst_reader: table of bursts, RAM model and a
// byte scoreboard, plus hand-written reset-mid-burst sequence.
module tb_sram_burst_reader;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    int            mode;       // 0: ready=1, 1: ready 1,0,0 repeating, 2: random
    bit            poke;       // pulse startBurst while busy
    int            exp_xfers;
    int            exp_first;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          startBurst;
  logic [AW-1:0] startAddress;
  logic [AW:0]   burstLength;
  logic [AW-1:0] memAddress;
  logic          memWriteEnable;
  logic [DW-1:0] memDataOut;
  logic [DW-1:0] dataOut;
  logic          dataValid;
  logic          dataReady;
  logic          busy;
  logic          done;

  sram_burst_reader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .startBurst    (startBurst),
    .startAddress  (startAddress),
    .burstLength   (burstLength),
    .memAddress    (memAddress),
    .memWriteEnable(memWriteEnable),
    .memDataOut    (memDataOut),
    .dataOut       (dataOut),
    .dataValid     (dataValid),
    .dataReady     (dataReady),
    .busy          (busy),
    .done          (done)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
  always @(posedge clock) memDataOut <= mem[memAddress];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  logic [DW-1:0] sb[$];
  logic [AW-1:0] addr_log[$];
  int            last_addr;
  int            xfer_count;
  int            first_xfer;
  int            last_xfer;
  int            first_byte;
  int            done_count;
  int            done_cyc;
  int            dv_seen;
  bit            busy_seen;
  bit            hold_pending = 1'b0;
  logic [DW-1:0] held;

  // Observes the DUT half a cycle away from the active edge.
  always @(negedge clock) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (busy) begin
        busy_seen = 1'b1;
        if (int'(memAddress) != last_addr) begin
          addr_log.push_back(memAddress);
          last_addr = int'(memAddress);
        end
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (dataValid) dv_seen++;
      if (hold_pending) begin
        check("hold_valid", dataValid, 1);
        check("hold_data", dataOut, held);
      end
      hold_pending = 1'b0;
      if (dataValid && dataReady) begin
        xfer_count++;
        last_xfer = cyc + 1;
        if (first_xfer < 0) begin
          first_xfer = cyc + 1;
          first_byte = int'(dataOut);
        end
        check("byte_expected", sb.size() > 0, 1);
        if (sb.size() > 0) check("byte_order", dataOut, sb.pop_front());
      end else if (dataValid) begin
        hold_pending = 1'b1;
        held         = dataOut;
      end
    end
  end

  function automatic logic ready_bit(input int mode, input int phase);
    case (mode)
      0:       return 1'b1;
      1:       return (phase % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic clear_monitor();
    sb.delete();
    addr_log.delete();
    last_addr  = -1;
    xfer_count = 0;
    first_xfer = -1;
    last_xfer  = -1;
    first_byte = -1;
    done_count = 0;
    done_cyc   = -1;
    dv_seen    = 0;
    busy_seen  = 1'b0;
  endtask

  task automatic run_burst(input vec_t v);
    int e0;
    int waited;
    int phase;
    clear_monitor();
    for (int i = 0; i < v.len; i++) sb.push_back(mem[(int'(v.addr) + i) % DEPTH]);
    phase        = 0;
    dataReady    = ready_bit(v.mode, phase);
    phase++;
    startAddress = v.addr;
    burstLength  = 12'(v.len);
    startBurst   = 1'b1;
    @(posedge clock); #1;
    e0         = cyc;
    startBurst = 1'b0;
    if (v.len > 0) check("first_address", memAddress, v.addr);
    waited = 0;
    while (done_count == 0 && waited < 2000) begin
      dataReady = ready_bit(v.mode, phase);
      phase++;
      if (v.poke && cyc == e0 + 2) begin
        startBurst   = 1'b1;
        startAddress = 11'h0AA;
        burstLength  = 12'd5;
      end else begin
        startBurst = 1'b0;
      end
      @(posedge clock); #1;
      waited++;
      if (v.len > 0 && cyc == e0 + 1) check("no_valid_before_e2", dataValid, 0);
      if (v.len > 0 && cyc == e0 + 2) check("valid_after_e2", dataValid, 1);
    end
    check("done_seen", done_count > 0, 1);
    startBurst = 1'b0;
    dataReady  = 1'b1;
    repeat (2) begin
      @(posedge clock); #1;
    end
    check("done_one_pulse", done_count, 1);
    check("idle_not_busy", busy, 0);
    check("mem_we_zero", memWriteEnable, 0);
    check("xfer_count", xfer_count, v.exp_xfers);
    check("scoreboard_empty", sb.size(), 0);
    if (v.len == 0) begin
      check("zero_no_valid", dv_seen, 0);
      check("zero_not_busy", busy_seen, 0);
      check("zero_done_timing", done_cyc, e0);
    end else begin
      check("first_byte", first_byte, v.exp_first);
      check("done_after_last", done_cyc, last_xfer);
      for (int i = 0; i < 4 && i < v.len; i++)
        check("address_order", (addr_log.size() > i) ? int'(addr_log[i]) : -1,
              (int'(v.addr) + i) % DEPTH);
      if (v.mode == 0) begin
        check("first_xfer_latency", first_xfer, e0 + 3);
        check("no_bubbles", last_xfer - first_xfer, v.len - 1);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_memAddress"}, memAddress, 0);
    check({tag, "_dataOut"}, dataOut, 0);
    check({tag, "_dataValid"}, dataValid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_memWriteEnable"}, memWriteEnable, 0);
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  vec_t vecs[7];

  initial begin
    int waited;
    vecs[0] = '{addr: 11'h010, len: 4,  mode: 0, poke: 1'b0, exp_xfers: 4,  exp_first: 'h10};
    vecs[1] = '{addr: 11'h7FE, len: 4,  mode: 0, poke: 1'b0, exp_xfers: 4,  exp_first: 'hFE};
    vecs[2] = '{addr: 11'h100, len: 8,  mode: 1, poke: 1'b1, exp_xfers: 8,  exp_first: 'h00};
    vecs[3] = '{addr: 11'h000, len: 0,  mode: 0, poke: 1'b0, exp_xfers: 0,  exp_first: -1};
    vecs[4] = '{addr: 11'h7F0, len: 40, mode: 2, poke: 1'b0, exp_xfers: 40, exp_first: 'hF0};
    vecs[5] = '{addr: 11'h123, len: 1,  mode: 0, poke: 1'b0, exp_xfers: 1,  exp_first: 'h23};
    vecs[6] = '{addr: 11'h055, len: 3,  mode: 1, poke: 1'b1, exp_xfers: 3,  exp_first: 'h55};

    reset        = 1'b1;
    startBurst   = 1'b0;
    startAddress = '0;
    burstLength  = '0;
    dataReady    = 1'b0;
    clear_monitor();
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset_state");
    reset = 1'b0;
    @(posedge clock); #1;

    foreach (vecs[k]) run_burst(vecs[k]);

    // Reset in the middle of a 10-byte burst, after three transfers.
    clear_monitor();
    for (int i = 0; i < 10; i++) sb.push_back(mem[11'h200 + i]);
    dataReady    = 1'b1;
    startAddress = 11'h200;
    burstLength  = 12'd10;
    startBurst   = 1'b1;
    @(posedge clock); #1;
    startBurst = 1'b0;
    waited     = 0;
    while (xfer_count < 3 && waited < 50) begin
      @(posedge clock); #1;
      waited++;
    end
    check("reset_reached_3", xfer_count, 3);
    #1 reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    sb.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    check("post_reset_no_valid", dataValid, 0);
    check("post_reset_idle", busy, 0);
    check("post_reset_no_xfers", xfer_count, 3);
    run_burst('{addr: 11'h300, len: 2, mode: 0, poke: 1'b0, exp_xfers: 2, exp_first: 'h00});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sram_burst_reader.md
SRAM_BURST_READER -- requirements
Module: sram_burst_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, SHALL set the RAM address width (2048 entries).
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the RAM data width.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 startBurst  input  1  SHALL request a burst; sampled only while idle.
REQ-006 startAddress  input  ADDR_WIDTH  SHALL be the first byte address; sampled with startBurst.
REQ-007 burstLength  input  ADDR_WIDTH+1  SHALL be the byte count, range 0..4095; sampled with startBurst.
REQ-008 memAddress  output  ADDR_WIDTH  SHALL drive the RAM port address, registered.
REQ-009 memWriteEnable  output  1  SHALL be constant 0.
REQ-010 memDataOut  input  DATA_WIDTH  SHALL be the RAM port read data, valid one cycle after the address.
REQ-011 dataOut  output  DATA_WIDTH  SHALL carry the streamed byte.
REQ-012 dataValid  output  1  SHALL qualify dataOut.
REQ-013 dataReady  input  1  SHALL be the consumer acceptance; a transfer occurs when dataValid and dataReady are both 1 at a rising edge.
REQ-014 busy  output  1  SHALL be 1 from acceptance of a burst until done.
REQ-015 done  output  1  SHALL pulse for exactly one cycle at burst completion.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, DRAIN, FINISH.
REQ-017 IDLE with startBurst=1 and burstLength>0 SHALL latch address and length, then go to ISSUE.
REQ-018 IDLE with startBurst=1 and burstLength=0 SHALL go to FINISH with no memory read and no dataValid.
REQ-019 startBurst outside IDLE SHALL be ignored.
REQ-020 In ISSUE, a read SHALL be issued in a cycle only if buffered entries plus in-flight reads, minus a transfer in that cycle, is at most 1.
REQ-021 An issued read SHALL present memAddress in cycle n and write memDataOut into the 2-entry output buffer at the end of cycle n+1.
REQ-022 Each issue SHALL increment the address modulo 2^ADDR_WIDTH (2047 wraps to 0) and decrement the remaining count.
REQ-023 When the remaining count reaches 0, the FSM SHALL go to DRAIN.
REQ-024 DRAIN SHALL go to FINISH in the cycle the last byte transfers.
REQ-025 FINISH SHALL assert done for one cycle, deassert busy in that cycle, and return to IDLE.
REQ-026 Latency: startBurst sampled at edge E0 SHALL produce memAddress=startAddress after E0 and first dataValid after E2.
REQ-027 With dataReady held at 1, throughput SHALL be one byte per cycle with no bubbles.
REQ-028 Once asserted, dataValid and dataOut SHALL hold stable until transfer; bytes SHALL stream in address order with none lost or duplicated.

Reset
REQ-029 Reset SHALL force IDLE, buffer empty, and in-flight flag clear.
REQ-030 Reset SHALL drive memAddress=0, dataOut=0, dataValid=0, busy=0, done=0, memWriteEnable=0.
REQ-031 Reset mid-burst SHALL abandon the burst; a read returning after reset SHALL be discarded.

Structure
REQ-032 A shared package SHALL hold ADDR_WIDTH, DATA_WIDTH defaults and the FSM state enumeration.
REQ-033 The 2-entry output buffer SHALL be a sub-module named byte_skid_buffer, with a valid/ready interface on both sides and an occupancy output.

Verification
REQ-034 Stream at full rate: RAM preloaded mem[i]=i[7:0], start addr 0x010, len 4, dataReady=1 -> bytes 0x10,0x11,0x12,0x13 on consecutive cycles, first after E2, done one cycle after the last transfer.
REQ-035 Wrap-around: addr 0x7FE, len 4 -> reads 0x7FE, 0x7FF, 0x000, 0x001 in order.
REQ-036 Backpressure: len 8, dataReady toggling 1,0,0,1,... -> all 8 bytes in order, dataOut stable while stalled, at most 2 buffered entries.
REQ-037 Zero length and ignored start: len 0 -> done pulse, no dataValid; startBurst pulsed while busy -> no effect on the active burst.
REQ-038 Reset mid-burst: reset after 3 of 10 transfers -> all outputs 0 immediately; a fresh burst of len 2 afterwards -> exactly 2 correct bytes.
